// File: rtl/tile_background_engine.sv
// Tile-map background renderer with hardware scroll, blink and frame count.
// CPU writes the map over Avalon-MM; pixels flow through a 3-stage pipeline.
module tile_background_engine #(
  parameter  int COLS      = 80,
  parameter  int ROWS      = 30,
  parameter  int TILE_W    = 8,
  parameter  int TILE_H    = 16,
  parameter  int IDX_W     = 4,
  localparam int MAP_WORDS = COLS * ROWS / 2,
  localparam int AW        = $clog2(MAP_WORDS) + 1,
  localparam int FAW       = $clog2(128 * TILE_H)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [AW-1:0]     AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [FAW-1:0]    font_addr,
  input  logic [TILE_W-1:0] font_data,
  output logic [IDX_W-1:0]  colorIdx,
  output logic              colorIdx_valid
);

  localparam int PW = COLS * TILE_W;
  localparam int PH = ROWS * TILE_H;
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);

  localparam logic [10:0] PW11 = 11'(PW);
  localparam logic [10:0] PH11 = 11'(PH);
  localparam logic [15:0] PW1  = 16'(PW);
  localparam logic [15:0] PW2  = 16'(2 * PW);
  localparam logic [15:0] PH1  = 16'(PH);
  localparam logic [15:0] PH2  = 16'(2 * PH);

  localparam logic [AW-2:0] R_SCROLL = '0;
  localparam logic [AW-2:0] R_CTRL   = (AW-1)'(1);
  localparam logic [AW-2:0] R_FRAME  = (AW-1)'(2);

  logic [31:0] mem [MAP_WORDS];

  logic [9:0]  sx_q, sx_d, sy_q, sy_d;
  logic [9:0]  asx_q, asx_d, asy_q, asy_d;
  logic        en_q, en_d, blk_q, blk_d;
  logic [15:0] frame_q, frame_d;
  logic [31:0] rdata_q, rdata_d;

  logic          is_reg, map_hit, wr, rd;
  logic [AW-2:0] a_lo;
  logic [15:0]   sx_half, sy_half;
  logic [31:0]   rd_word;
  logic          fs;

  assign a_lo    = AVL_ADDR[AW-2:0];
  assign is_reg  = AVL_ADDR[AW-1];
  assign map_hit = !is_reg && ({1'b0, a_lo} < AW'(MAP_WORDS));
  assign wr      = AVL_CS && AVL_WRITE;
  assign rd      = AVL_CS && AVL_READ;
  assign fs      = pix_valid && (DrawX == '0) && (DrawY == '0);

  // Fold into [0,lim) with one subtraction; out-of-range keeps old value
  function automatic logic [9:0] fold(
    input logic [9:0]  old,
    input logic [15:0] v,
    input logic [15:0] lim,
    input logic [15:0] lim2
  );
    if (v < lim)  return v[9:0];
    if (v < lim2) return 10'(v - lim);
    return old;
  endfunction

  always_ff @(posedge CLK) begin
    if (wr && map_hit) begin
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b])
          mem[a_lo][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
    end
  end

  always_comb begin
    sx_half = {
      AVL_BYTE_EN[1] ? AVL_WRITEDATA[15:8] : {6'b0, sx_q[9:8]},
      AVL_BYTE_EN[0] ? AVL_WRITEDATA[7:0]  : sx_q[7:0]
    };
    sy_half = {
      AVL_BYTE_EN[3] ? AVL_WRITEDATA[31:24] : {6'b0, sy_q[9:8]},
      AVL_BYTE_EN[2] ? AVL_WRITEDATA[23:16] : sy_q[7:0]
    };
    sx_d    = sx_q;
    sy_d    = sy_q;
    en_d    = en_q;
    blk_d   = blk_q;
    if (wr && is_reg && a_lo == R_SCROLL) begin
      sx_d = fold(sx_q, sx_half, PW1, PW2);
      sy_d = fold(sy_q, sy_half, PH1, PH2);
    end
    if (wr && is_reg && a_lo == R_CTRL && AVL_BYTE_EN[0]) begin
      en_d  = AVL_WRITEDATA[0];
      blk_d = AVL_WRITEDATA[1];
    end
    asx_d   = fs ? sx_q : asx_q;
    asy_d   = fs ? sy_q : asy_q;
    frame_d = fs ? frame_q + 16'd1 : frame_q;
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      map_hit:
        rd_word = mem[a_lo];
      is_reg && a_lo == R_SCROLL:
        rd_word = {6'b0, sy_q, 6'b0, sx_q};
      is_reg && a_lo == R_CTRL:
        rd_word = {30'b0, blk_q, en_q};
      is_reg && a_lo == R_FRAME:
        rd_word = {16'b0, frame_q};
      default: ;
    endcase
    rdata_d = rd ? rd_word : rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sx_q    <= '0;
      sy_q    <= '0;
      asx_q   <= '0;
      asy_q   <= '0;
      en_q    <= 1'b0;
      blk_q   <= 1'b0;
      frame_q <= '0;
      rdata_q <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      asx_q   <= asx_d;
      asy_q   <= asy_d;
      en_q    <= en_d;
      blk_q   <= blk_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
    end
  end

  assign AVL_READDATA = rdata_q;

  // Stage 0: scrolled coordinates and map address
  logic [10:0]   sum_x, sum_y;
  logic [9:0]    vx, vy, col, row;
  logic [AW-1:0] tidx;
  logic [AW-2:0] word_d;
  logic [XW-1:0] xr_d;
  logic [YW-1:0] yr_d;

  always_comb begin
    sum_x  = {1'b0, DrawX} + {1'b0, asx_d};
    sum_y  = {1'b0, DrawY} + {1'b0, asy_d};
    vx     = (sum_x >= PW11) ? 10'(sum_x - PW11) : sum_x[9:0];
    vy     = (sum_y >= PH11) ? 10'(sum_y - PH11) : sum_y[9:0];
    col    = vx / 10'(TILE_W);
    row    = vy / 10'(TILE_H);
    tidx   = AW'(row) * AW'(COLS) + AW'(col);
    word_d = tidx[AW-1:1];
    xr_d   = XW'(vx % 10'(TILE_W));
    yr_d   = YW'(vy % 10'(TILE_H));
  end

  logic [31:0]   map_q;
  logic          s1_v_q, s1_sel_q;
  logic [XW-1:0] s1_xr_q;
  logic [YW-1:0] s1_yr_q;

  always_ff @(posedge CLK) begin
    map_q <= mem[word_d];
  end

  // Stage 1: half-word select and font lookup
  logic [15:0] ent;

  assign ent       = s1_sel_q ? map_q[31:16] : map_q[15:0];
  assign font_addr = FAW'(ent[14:8]) * FAW'(TILE_H) + FAW'(s1_yr_q);

  logic             s2_v_q, s2_blink_q;
  logic [IDX_W-1:0] s2_fg_q, s2_bg_q;
  logic [XW-1:0]    s2_xr_q;

  // Stage 2: pixel bit, blink and colour select
  logic             fbit, blank;
  logic [IDX_W-1:0] cidx_d;
  logic [IDX_W-1:0] cidx_q;
  logic             cval_q;

  always_comb begin
    fbit   = font_data[XW'(TILE_W - 1) - s2_xr_q];
    blank  = blk_q && s2_blink_q && frame_q[5];
    cidx_d = '0;
    if (s2_v_q && en_q)
      cidx_d = (fbit && !blank) ? s2_fg_q : s2_bg_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_v_q     <= 1'b0;
      s1_sel_q   <= 1'b0;
      s1_xr_q    <= '0;
      s1_yr_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_blink_q <= 1'b0;
      s2_fg_q    <= '0;
      s2_bg_q    <= '0;
      s2_xr_q    <= '0;
      cidx_q     <= '0;
      cval_q     <= 1'b0;
    end else begin
      s1_v_q     <= pix_valid;
      s1_sel_q   <= tidx[0];
      s1_xr_q    <= xr_d;
      s1_yr_q    <= yr_d;
      s2_v_q     <= s1_v_q;
      s2_blink_q <= ent[15];
      s2_fg_q    <= IDX_W'(ent[7:4]);
      s2_bg_q    <= IDX_W'(ent[3:0]);
      s2_xr_q    <= s1_xr_q;
      cidx_q     <= cidx_d;
      cval_q     <= s2_v_q;
    end
  end

  assign colorIdx       = cidx_q;
  assign colorIdx_valid = cval_q;

endmodule

// File: tb/tb_tile_background_engine.sv
// Scoreboard bench for tile_background_engine with a synchronous model font ROM.
// Font ROM row = font_addr[7:0] ^ 8'h5A.
module tb_tile_background_engine;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [11:0] AVL_ADDR = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  colorIdx;
  logic        colorIdx_valid;

  tile_background_engine dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .font_addr(font_addr), .font_data(font_data),
    .colorIdx(colorIdx), .colorIdx_valid(colorIdx_valid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) font_data <= font_addr[7:0] ^ 8'h5A;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int due; bit v; logic [3:0] idx; int tag;} pexp_t;
  typedef struct {int due; logic [31:0] val; int tag;} rexp_t;

  pexp_t pq[$];
  rexp_t rq[$];
  int total = 0, bad = 0, fr = 0, ptag = 0;
  bit mon_on = 1'b0;

  localparam logic [11:0] A_W0     = 12'h000;
  localparam logic [11:0] A_W39    = 12'h027;
  localparam logic [11:0] A_SCROLL = 12'h800;
  localparam logic [11:0] A_CTRL   = 12'h801;
  localparam logic [11:0] A_FRAME  = 12'h802;

  always @(negedge CLK) begin
    pexp_t pe;
    rexp_t re;
    if (mon_on) begin
      while (pq.size() > 0 && pq[0].due < cyc) begin
        pe = pq.pop_front();
        total++; bad++;
        $display("FAIL pix_missed tag=%0d", pe.tag);
      end
      total++;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front();
        if (colorIdx_valid !== pe.v || colorIdx !== pe.idx) begin
          bad++;
          $display("FAIL pix tag=%0d got v=%0b idx=%0d want v=%0b idx=%0d",
                   pe.tag, colorIdx_valid, colorIdx, pe.v, pe.idx);
        end
      end else if (colorIdx_valid !== 1'b0 || colorIdx !== 4'd0) begin
        bad++;
        $display("FAIL idle cyc=%0d got v=%0b idx=%0d want v=0 idx=0",
                 cyc, colorIdx_valid, colorIdx);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        re = rq.pop_front();
        total++;
        if (AVL_READDATA !== re.val) begin
          bad++;
          $display("FAIL rd tag=%0d got %h want %h", re.tag, AVL_READDATA, re.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit v, input logic [3:0] e);
    pix_valid = v;
    DrawX = 10'(x);
    DrawY = 10'(y);
    pq.push_back('{cyc + 3, v, v ? e : 4'd0, ptag});
    ptag++;
    if (v && x == 0 && y == 0) fr++;
    step();
    pix_valid = 1'b0;
  endtask

  // Expected indices packed as nibbles, leftmost pixel in the top nibble
  task automatic run(input int x0, input int y, input logic [31:0] ex, input int n);
    for (int i = 0; i < n; i++)
      pix(x0 + i, y, 1'b1, ex[31-4*i -: 4]);
  endtask

  task automatic avw(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    step();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avr(input logic [11:0] a, input logic [31:0] e, input int tag);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    rq.push_back('{cyc + 1, e, tag});
    step();
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    mon_on = 1'b1;
    rq.push_back('{cyc, 32'h0, 1});
    avr(A_FRAME, 32'h0, 2);
    avr(A_CTRL, 32'h0, 3);
    avr(A_SCROLL, 32'h0, 4);

    avw(A_W0, 32'h0A41_1230, 4'hF);
    avw(A_W39, 32'h0B65_0000, 4'hF);
    avr(A_W0, 32'h0A41_1230, 5);

    pix(0, 2, 1, 0); pix(1, 2, 0, 0); pix(2, 2, 1, 0);
    pix(3, 2, 1, 0); pix(4, 2, 0, 0); pix(5, 2, 1, 0);
    idle(4);

    avw(A_CTRL, 32'h1, 4'hF);
    avr(A_CTRL, 32'h1, 6);
    run(0, 0, 32'h0333_3030, 8);
    pix(8, 0, 0, 0);
    run(8, 0, 32'h4444_4141, 8);
    idle(4);

    avw(A_SCROLL, 32'h0000_027C, 4'hF);
    run(0, 1, 32'h0333_0000, 4);
    idle(4);
    avr(A_SCROLL, 32'h0000_027C, 7);
    run(0, 0, 32'h6565_0333, 8);
    idle(4);
    avr(A_FRAME, 32'd2, 8);

    avw(A_SCROLL, 32'h0000_02BC, 4'hF);
    avr(A_SCROLL, 32'h0000_003C, 10);
    avw(A_SCROLL, 32'h0000_0578, 4'hF);
    avr(A_SCROLL, 32'h0000_003C, 11);
    avw(A_SCROLL, 32'h01F4_003C, 4'hF);
    avr(A_SCROLL, 32'h0014_003C, 12);
    avw(A_SCROLL, 32'h03E8_0000, 4'hF);
    avr(A_SCROLL, 32'h0014_0000, 13);
    avw(A_SCROLL, 32'hFFFF_FFFF, 4'h0);
    avr(A_SCROLL, 32'h0014_0000, 14);
    avw(A_SCROLL, 32'h0000_0005, 4'h1);
    avr(A_SCROLL, 32'h0014_0005, 15);
    avw(A_SCROLL, 32'h0, 4'hF);
    avr(A_SCROLL, 32'h0, 16);

    avw(A_W0, 32'h0A41_9230, 4'hF);
    avw(A_CTRL, 32'h3, 4'hF);
    run(0, 0, 32'h0333_3030, 8);
    run(8, 0, 32'h4444_4141, 8);
    idle(4);
    repeat (28) pix(0, 0, 1, 0);
    idle(4);
    avr(A_FRAME, 32'd31, 20);
    run(0, 0, 32'h0000_0000, 8);
    run(8, 0, 32'h4444_4141, 8);
    idle(4);
    avr(A_FRAME, 32'd32, 21);
    avw(A_CTRL, 32'h1, 4'hF);
    run(0, 0, 32'h0333_3030, 8);
    idle(4);
    avr(A_FRAME, 32'd33, 22);

    run(8, 3, 32'h4440_0000, 3);
    RESET = 1'b1;
    pix_valid = 1'b1; DrawX = 10'd11; DrawY = 10'd3;
    while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
    rq.push_back('{cyc + 1, 32'h0, 30});
    step();
    RESET = 1'b0;
    pix_valid = 1'b0;
    fr = 0;
    idle(4);
    avr(A_W0, 32'h0A41_9230, 31);
    avr(A_FRAME, 32'h0, 32);
    avr(A_CTRL, 32'h0, 33);
    avr(A_SCROLL, 32'h0, 34);
    pix(0, 2, 1, 0); pix(1, 2, 1, 0); pix(2, 2, 0, 0); pix(3, 2, 1, 0);
    idle(5);

    total++;
    if (pq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL leftover got pq=%0d rq=%0d want 0", pq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
